// File: rtl/bip_exec_ctrl_pkg.sv
// Shared definitions for the accumulator-processor execution sequencer.
//   - opcode constants (HALT..SUBI)
//   - FSM state encoding, kept as plain 2-bit constants so legacy code that
//     compares against the raw encoding keeps working
//   - run/step mode flag
package bip_exec_ctrl_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_LOADI = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SUBI  = 5'b00111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_t;

endpackage

// File: rtl/bip_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   clr   : synchronous clear (takes priority over inc)
//   inc   : increment by one; the count sticks at all-ones
//   count : current value
module bip_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bip_exec_ctrl.sv
// Execution sequencer for the accumulator processor: fetch/execute rhythm,
// run and single-step modes, halt detection and retired-instruction count.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_start / i_step         enter run mode / execute one instruction (IDLE only)
//   i_OPcode                 opcode from program memory, valid in EXEC
//   i_WrPC/i_WrAcc/i_WrRam   raw decoder write enables
//   i_PC                     current PC (breakpoint compare only)
//   o_WrPC/o_WrAcc/o_WrRam   write enables qualified to EXEC of a non-HALT
//   o_busy                   FETCH or EXEC
//   o_halted                 HALTED state
//   o_done                   pulse on step completion, HALT or breakpoint
//   o_instr_cnt              retired non-HALT instructions, saturating
//
// Build option: BIP_CTRL_BREAKPOINT_EN adds i_brk_addr / i_brk_valid; in run
// mode a FETCH at the breakpoint address returns to IDLE without executing.
module bip_exec_ctrl
  import bip_exec_ctrl_pkg::*;
#(
  parameter int unsigned N_OP  = 5,
  parameter int unsigned PC_W  = 11,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_step,
  input  logic [N_OP-1:0]  i_OPcode,
  input  logic             i_WrPC,
  input  logic             i_WrAcc,
  input  logic             i_WrRam,
  input  logic [PC_W-1:0]  i_PC,
`ifdef BIP_CTRL_BREAKPOINT_EN
  input  logic [PC_W-1:0]  i_brk_addr,
  input  logic             i_brk_valid,
`endif
  output logic             o_WrPC,
  output logic             o_WrAcc,
  output logic             o_WrRam,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic [CNT_W-1:0] o_instr_cnt
);

  logic [1:0] state, state_nxt;
  mode_t      mode, mode_nxt;
  logic       is_halt;
  logic       in_exec;
  logic       retire;
  logic       brk_hit;

  assign is_halt = (i_OPcode == N_OP'(OP_HALT));
  assign in_exec = (state == ST_EXEC);
  // A reset arriving during EXEC must suppress that cycle's writes.
  assign retire  = in_exec && !is_halt && !i_reset;

`ifdef BIP_CTRL_BREAKPOINT_EN
  // Run mode only, so a single step from the resulting IDLE executes the
  // breakpointed instruction.
  assign brk_hit = (state == ST_FETCH) && (mode == MODE_RUN) &&
                   i_brk_valid && (i_PC == i_brk_addr);
`else
  logic unused_pc;
  assign unused_pc = ^i_PC;
  assign brk_hit   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_FETCH;
          mode_nxt  = MODE_RUN;
        end else if (i_step) begin
          state_nxt = ST_FETCH;
          mode_nxt  = MODE_STEP;
        end
      end
      ST_FETCH: state_nxt = brk_hit ? ST_IDLE : ST_EXEC;
      ST_EXEC: begin
        if (is_halt) begin
          state_nxt = ST_HALTED;
        end else if (mode == MODE_RUN) begin
          state_nxt = ST_FETCH;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      mode  <= MODE_STEP;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
    end
  end

  assign o_WrPC   = i_WrPC  & retire;
  assign o_WrAcc  = i_WrAcc & retire;
  assign o_WrRam  = i_WrRam & retire;
  assign o_busy   = (state == ST_FETCH) || (state == ST_EXEC);
  assign o_halted = (state == ST_HALTED);
  assign o_done   = !i_reset &&
                    ((in_exec && (is_halt || (mode == MODE_STEP))) || brk_hit);

  bip_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (i_clk),
    .clr   (i_reset),
    .inc   (retire),
    .count (o_instr_cnt)
  );

endmodule

// File: doc/bip_exec_ctrl.md
Name: bip_exec_ctrl

Overview:
- Execution sequencer for the accumulator processor. It drives the fetch/execute rhythm, run and single-step modes, and halt detection.
- Sits between the debug/UART front end (start/step commands) and the datapath.
- Takes the opcode from synchronous program memory and the raw enables from the instruction decoder. Each write enable is qualified so it reaches PC, ACC or data RAM only in the EXEC cycle.
- Counts retired instructions for the debug unit.

Parameters:
- N_OP, 5, opcode width (HALT = 5'b00000).
- PC_W, 11, program-counter width (breakpoint compare only).
- CNT_W, 16, retired-instruction counter width.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  pulse: enter continuous RUN from IDLE.
- i_step  in  1  pulse: execute exactly one instruction from IDLE.
- i_OPcode  in  N_OP  opcode from program memory, valid in EXEC.
- i_WrPC  in  1  raw decoder PC write enable.
- i_WrAcc  in  1  raw decoder ACC write enable.
- i_WrRam  in  1  raw decoder data-RAM write enable.
- i_PC  in  PC_W  current PC (used only with the breakpoint feature).
- o_WrPC  out  1  qualified PC write enable.
- o_WrAcc  out  1  qualified ACC write enable.
- o_WrRam  out  1  qualified RAM write enable.
- o_busy  out  1  high in FETCH or EXEC.
- o_halted  out  1  high in HALTED.
- o_done  out  1  one-cycle pulse when a step completes or HALT is reached.
- o_instr_cnt  out  CNT_W  retired non-HALT instructions.

Behaviour:
- Reset: all outputs 0, state IDLE, mode flag = step, counter = 0. Reset mid-instruction aborts with no qualified enable in that cycle.
- Reset is synchronous and active-high, on i_clk only. There is no other clock.
- States and transitions:
  - IDLE: i_start → FETCH with mode=run. Else i_step → FETCH with mode=step. Both asserted together: start wins.
  - FETCH (1 cycle): program memory registers the instruction at PC. Always → EXEC.
  - EXEC (1 cycle):
    - i_OPcode == HALT → HALTED, o_done=1, no enables, counter unchanged.
    - Otherwise o_WrPC/o_WrAcc/o_WrRam = raw enables; counter += 1, saturating at all-ones.
    - Then: mode=run → FETCH; mode=step → IDLE with o_done=1.
  - HALTED: terminal. Leaving it requires i_reset; i_start and i_step are ignored.
- Qualified enables are combinational: o_WrX = i_WrX & (state==EXEC & opcode!=HALT). They are 0 in every other state.
- Throughput and latency: 2 cycles per instruction. In step mode o_done asserts in the EXEC cycle, 2 cycles after the i_step sample.
- i_start/i_step outside IDLE are ignored and not queued.
- o_busy = (FETCH|EXEC). o_halted is registered with the state.

Optional Feature:
- BIP_CTRL_BREAKPOINT_EN: adds input i_brk_addr [PC_W] and i_brk_valid.
- With the macro, in run mode a FETCH→EXEC transition with i_brk_valid && i_PC==i_brk_addr does not execute. The state goes → IDLE with o_done=1, no enables and no count.
- A subsequent i_step from that IDLE executes the breakpointed instruction, because the breakpoint check applies to run mode only.
- Without the macro, the ports are absent and the behaviour is as above.

Decomposition:
- Shared package/header: opcode localparams (HALT..SUBI), FSM state encoding (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2, HALTED=2'd3), mode encoding.
- One natural sub-module: bip_sat_counter (CNT_W-wide saturating counter with increment enable and synchronous clear). Everything else stays in bip_exec_ctrl.

Test Plan:
- Single step: reset, i_step=1 one cycle, opcode ADDI (5'b00101), raw WrPC=WrAcc=1 → o_WrPC=o_WrAcc=1 exactly one cycle, 2 cycles after i_step; o_done pulses; o_instr_cnt=1; back to IDLE.
- Run to halt: i_start, opcodes LOADI, ADD, STORE, HALT → 3 EXEC cycles with enables; o_WrRam=1 only on STORE; o_halted=1; o_instr_cnt=3; later i_start/i_step → no change.
- Simultaneous i_start & i_step in IDLE → run mode; continues past first instruction without o_done.
- Reset mid-run: assert i_reset during EXEC of SUB → same-cycle enables seen at 0 by next edge; all outputs 0, o_instr_cnt=0, state IDLE.
- Saturation: CNT_W=4, run 20 non-HALT instructions → o_instr_cnt holds 4'hF.
- (BIP_CTRL_BREAKPOINT_EN) i_brk_addr=3, i_brk_valid=1, run → 3 instructions retired, stop in IDLE with o_done; i_step → instruction at 3 executes, count=4.
